// File: rtl/accum_bank_ctrl.sv
// accum_bank_ctrl: multi-lane accumulator bank with forwarded read-modify-write,
// clear-on-read drain stream, reset-time RAM initialisation and sticky overflow.
module accum_bank_ctrl #(
    parameter int LANES = 2,
    parameter int IN_W  = 64,
    parameter int ACC_W = 80,
    parameter int DEPTH = 4,
    parameter int ADR_W = 2,
    localparam int LN_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*IN_W-1:0]  in_num,
    input  logic [LANES-1:0]       in_sign,
    input  logic [LANES*ADR_W-1:0] in_adr,
    input  logic                   drain_start,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_W-1:0]       out_data,
    output logic [LN_W-1:0]        out_lane,
    output logic [ADR_W-1:0]       out_adr,
    output logic                   out_last,
    output logic [LANES-1:0]       ovf
);

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_FLUSH,
        S_DRAIN
    } state_e;

    state_e state_q, state_d;

    logic [ADR_W-1:0] init_cnt_q, init_cnt_d;
    logic             flush_cnt_q, flush_cnt_d;

    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_data_q, out_data_d;
    logic [LN_W-1:0]  out_lane_q, out_lane_d;
    logic [ADR_W-1:0] out_adr_q, out_adr_d;
    logic             out_last_q, out_last_d;
    logic [LANES-1:0] ovf_q, ovf_d;

    logic [ACC_W-1:0] mem_q [LANES][DEPTH];

    logic                             a_vld_q, a_vld_d;
    logic [LANES-1:0][ADR_W-1:0]      a_adr_q, a_adr_d;
    logic [LANES-1:0][ACC_W-1:0]      a_val_q, a_val_d;
    logic [LANES-1:0][ACC_W-1:0]      rd_q;

    logic                             b_vld_q;
    logic [LANES-1:0][ADR_W-1:0]      b_adr_q;
    logic [LANES-1:0][ACC_W-1:0]      b_res_q;

    logic [LANES-1:0][ACC_W-1:0]      base;
    logic [LANES-1:0][ACC_W-1:0]      sum;
    logic [LANES-1:0]                 ovf_set;

    logic [LANES-1:0]                 we;
    logic [LANES-1:0][ADR_W-1:0]      wadr;
    logic [LANES-1:0][ACC_W-1:0]      wdata;

    logic             hs;
    logic [LN_W-1:0]  nxt_lane;
    logic [ADR_W-1:0] nxt_adr;
    logic             nxt_last;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_lane  = out_lane_q;
    assign out_adr   = out_adr_q;
    assign out_last  = out_last_q;
    assign ovf       = ovf_q;

    assign hs = (state_q == S_DRAIN) && out_valid_q && out_ready;

    // Lane-major walk: the address wraps first, then the lane advances.
    assign nxt_adr  = out_adr_q + ADR_W'(1);
    assign nxt_lane = (out_adr_q == ADR_W'(DEPTH - 1))
                    ? out_lane_q + LN_W'(1) : out_lane_q;
    assign nxt_last = (nxt_lane == LN_W'(LANES - 1))
                   && (nxt_adr == ADR_W'(DEPTH - 1));

    always_comb begin
        a_vld_d = in_valid && in_ready;
        for (int k = 0; k < LANES; k++) begin
            a_adr_d[k] = in_adr[k*ADR_W +: ADR_W];
            a_val_d[k] = {{(ACC_W-IN_W){in_sign[k]}},
                          in_num[k*IN_W +: IN_W]};
        end
    end

    // The read issued in stage A misses the write retiring on the same edge.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            base[k] = (b_vld_q && (b_adr_q[k] == a_adr_q[k]))
                    ? b_res_q[k] : rd_q[k];
            sum[k]  = base[k] + a_val_q[k];
            ovf_set[k] = a_vld_q
                      && (base[k][ACC_W-1] == a_val_q[k][ACC_W-1])
                      && (sum[k][ACC_W-1] != base[k][ACC_W-1]);
        end
    end

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            we[k]    = 1'b0;
            wadr[k]  = '0;
            wdata[k] = '0;
            if (state_q == S_INIT) begin
                we[k]   = 1'b1;
                wadr[k] = init_cnt_q;
            end else if (a_vld_q) begin
                we[k]    = 1'b1;
                wadr[k]  = a_adr_q[k];
                wdata[k] = sum[k];
            end else if (hs && (out_lane_q == LN_W'(k))) begin
                we[k]   = 1'b1;
                wadr[k] = out_adr_q;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        flush_cnt_d = flush_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_lane_d  = out_lane_q;
        out_adr_d   = out_adr_q;
        out_last_d  = out_last_q;
        ovf_d       = ovf_q | ovf_set;
        unique case (state_q)
            S_INIT: begin
                init_cnt_d = init_cnt_q + ADR_W'(1);
                if (init_cnt_q == ADR_W'(DEPTH - 1)) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (drain_start) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = 1'b0;
                    ovf_d       = '0;
                end
            end
            S_FLUSH: begin
                flush_cnt_d = 1'b1;
                if (flush_cnt_q) begin
                    state_d     = S_DRAIN;
                    out_valid_d = 1'b1;
                    out_lane_d  = '0;
                    out_adr_d   = '0;
                    out_data_d  = mem_q[0][0];
                    out_last_d  = 1'b0;
                end
            end
            S_DRAIN: begin
                if (hs) begin
                    if (out_last_q) begin
                        state_d     = S_IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        out_lane_d = nxt_lane;
                        out_adr_d  = nxt_adr;
                        out_data_d = mem_q[nxt_lane][nxt_adr];
                        out_last_d = nxt_last;
                    end
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_INIT;
            init_cnt_q  <= '0;
            flush_cnt_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_lane_q  <= '0;
            out_adr_q   <= '0;
            out_last_q  <= 1'b0;
            ovf_q       <= '0;
            a_vld_q     <= 1'b0;
            a_adr_q     <= '0;
            a_val_q     <= '0;
            b_vld_q     <= 1'b0;
            b_adr_q     <= '0;
            b_res_q     <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_lane_q  <= out_lane_d;
            out_adr_q   <= out_adr_d;
            out_last_q  <= out_last_d;
            ovf_q       <= ovf_d;
            a_vld_q     <= a_vld_d;
            if (a_vld_d) begin
                a_adr_q <= a_adr_d;
                a_val_q <= a_val_d;
            end
            b_vld_q     <= a_vld_q;
            b_adr_q     <= a_adr_q;
            b_res_q     <= sum;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (we[k]) begin
                mem_q[k][wadr[k]] <= wdata[k];
            end
            rd_q[k] <= mem_q[k][a_adr_d[k]];
        end
    end

endmodule

// File: doc/accum_bank_ctrl.md
# accum_bank_ctrl

Parametrised multi-lane accumulator bank for the matrix multiplier's product-sum stage. Each lane owns a DEPTH-entry accumulator RAM. Every valid cycle the block sign-extends one product per lane and adds it to the addressed entry, forwarding over read-modify-write hazards. On command it drains all entries through a valid/ready stream and clears each entry as it is read, with reset-time RAM initialisation and sticky per-lane overflow flags.

## Interface
Parameters:
- LANES, 2: number of independent accumulator lanes (2 = even/odd pair).
- IN_W, 64: product magnitude width per lane.
- ACC_W, 80: accumulator width; must be greater than IN_W.
- DEPTH, 4: entries per lane; must be a power of two, 2..256.
- ADR_W, 2: log2(DEPTH).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  products valid this cycle; accepted only when in_ready=1.
- in_ready  out  1  high only in IDLE.
- in_num  in  LANES*IN_W  lane k at bits [k*IN_W +: IN_W].
- in_sign  in  LANES  per-lane sign bit, replicated into the upper ACC_W-IN_W bits.
- in_adr  in  LANES*ADR_W  per-lane target entry.
- drain_start  in  1  one-cycle request to read out and clear all entries.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- out_data  out  ACC_W  accumulator value.
- out_lane  out  max(1,log2(LANES))  lane of out_data.
- out_adr  out  ADR_W  entry of out_data.
- out_last  out  1  marks the final word of a drain.
- ovf  out  LANES  sticky signed-overflow flag per lane.

## Operation
- States: INIT, IDLE, FLUSH, DRAIN.
- INIT:
  - Entered on rst. Writes zero to entry i of every lane in cycle i.
  - Lasts exactly DEPTH cycles, then goes to IDLE.
- IDLE accumulate pipeline:
  - Stage A registers the accepted inputs and issues a synchronous RAM read.
  - Stage B computes acc + sext({in_sign,in_num}) modulo 2^ACC_W, two's complement, and writes it back.
  - A lane with in_valid=1 always updates; there is no per-lane enable.
- Hazard forwarding:
  - If stage A's lane address equals stage B's address for the same lane, stage B's result replaces the RAM read data.
  - Back-to-back updates to one entry must sum exactly.
- Overflow: ovf[k] sets when operands share a sign and the result's sign differs. The wrapped value is stored anyway.
- drain_start:
  - Sampled only in IDLE; ignored in any other state.
  - On acceptance, in_ready drops next cycle, ovf clears, and the state goes to FLUSH.
- FLUSH: 2 cycles, letting in-flight stage A/B writes retire. Then DRAIN.
- DRAIN:
  - Visits entries lane-major: lane 0 adr 0..DEPTH-1, then lane 1, and so on.
  - Holds out_data/out_lane/out_adr/out_last stable while out_valid & !out_ready.
  - Each handshake writes zero to the visited entry.
  - out_last=1 on lane LANES-1, adr DEPTH-1. Its handshake returns the state to IDLE.
  - Exactly LANES*DEPTH words per drain.
- in_valid and drain_start in the same IDLE cycle: both accepted. The input is accumulated before the drain reads it (FLUSH covers it).
- rst in any state, including mid-drain:
  - Aborts the drain and re-enters INIT.
  - Partially drained data is lost.

## Timing
- Reset values: in_ready=0, out_valid=0, out_last=0, out_data=0, out_lane=0, out_adr=0, ovf=0.
- in_ready=1 from cycle DEPTH after rst deasserts.
- Accumulate latency: an input accepted in cycle T is written in T+1 and visible to a read issued in T+1, via forwarding.
- Throughput: one input per cycle per lane in IDLE.
- Drain timing:
  - drain_start accepted in T gives out_valid=1 in T+3.
  - With out_ready held high, one word per cycle.
  - in_ready=1 in the cycle after the out_last handshake.
- out_valid never drops without a handshake except on rst.

## Test plan
- Reset/init: DEPTH=4. Assert rst 1 cycle. in_ready=0 for 4 cycles then 1. Immediate drain returns 8 zeros with out_last on word 8.
- Hazard: lane 0 adr 1 gets +5, +7, -3 (sign=1, num=2^64-3) on consecutive cycles. Drain gives lane0/adr1 = 9 and all other entries 0.
- Backpressure: preload lane1/adr3=0x1234. Drain with out_ready toggled 1,0,0,1. Each word held stable while stalled, order lane-major. A second drain returns all zeros (clear-on-read).
- Overflow: ACC_W=80. Add 2^63-1 to lane 0 adr 0 repeatedly until past 2^79-1. ovf[0]=1, ovf[1]=0. Stored value wraps. ovf clears on the next drain_start.
- Simultaneous: in_valid (lane0 adr0 +4) in the same cycle as drain_start. The drain's first word is 4. in_valid during DRAIN is ignored (in_ready=0) and not accumulated.
- Mid-drain reset: assert rst after 3 handshakes. out_valid=0 next cycle, INIT runs 4 cycles, and a subsequent drain returns all zeros.
